ctl_fsm: RTL

- Second-generation on-core control unit: explicit multi-state sequencer replacing the ad-hoc decode flag/substage scheme.
- Fetches 32-bit instructions over a request/valid handshake and decodes them.
- Reads operands through a combinational register-file read port, drives the combinational ALU and writes results back through a registered write port.
- Adds halt/wake, a jump, a register-register add, and trapping on illegal opcodes.

---
 rtl/ctl_fsm_pkg.sv | 54 +++++
 rtl/ctl_decode.sv | 38 +++
 rtl/ctl_fsm.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ctl_fsm_pkg.sv
// rtl/ctl_fsm_pkg.sv - shared opcode, field, register and ALU types for the control sequencer
package ctl_fsm_pkg;

  localparam logic [7:0] OPC_NOP  = 8'h00;
  localparam logic [7:0] OPC_HLT  = 8'h01;
  localparam logic [7:0] OPC_IMOV = 8'h02;
  localparam logic [7:0] OPC_IADD = 8'h03;
  localparam logic [7:0] OPC_ISUB = 8'h04;
  localparam logic [7:0] OPC_IAND = 8'h05;
  localparam logic [7:0] OPC_IOR  = 8'h06;
  localparam logic [7:0] OPC_ADD  = 8'h07;
  localparam logic [7:0] OPC_JMP  = 8'h08;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 16;
  localparam int IMM_LSB = 16;

  typedef logic [7:0] reg_t;

  typedef enum logic [1:0] {
    ALU_OP_ADD = 2'd0,
    ALU_OP_SUB = 2'd1,
    ALU_OP_AND = 2'd2,
    ALU_OP_OR  = 2'd3
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_READ_RS,
    ST_EXEC,
    ST_WB,
    ST_HALT,
    ST_TRAP
  } ctl_state_t;

  function automatic logic [7:0] inst_opc(input logic [31:0] inst);
    return inst[OPC_LSB +: 8];
  endfunction

  function automatic reg_t inst_rd(input logic [31:0] inst);
    return inst[RD_LSB +: 8];
  endfunction

  function automatic reg_t inst_rs(input logic [31:0] inst);
    return inst[RS_LSB +: 8];
  endfunction

  function automatic logic [15:0] inst_imm(input logic [31:0] inst);
    return inst[IMM_LSB +: 16];
  endfunction

endpackage

// File: rtl/ctl_decode.sv
// rtl/ctl_decode.sv - combinational opcode decode into successor state and ALU operation
module ctl_decode
  import ctl_fsm_pkg::*;
(
  input  logic [7:0]  opcode,
  output ctl_state_t  next_state,
  output alu_op_t     alu_op,
  output logic        is_legal
);

  always_comb begin
    next_state = ST_TRAP;
    alu_op     = ALU_OP_ADD;
    is_legal   = 1'b1;
    case (opcode)
      OPC_NOP:  next_state = ST_FETCH;
      OPC_HLT:  next_state = ST_HALT;
      OPC_IMOV: next_state = ST_WB;
      OPC_IADD: next_state = ST_EXEC;
      OPC_ISUB: begin
        next_state = ST_EXEC;
        alu_op     = ALU_OP_SUB;
      end
      OPC_IAND: begin
        next_state = ST_EXEC;
        alu_op     = ALU_OP_AND;
      end
      OPC_IOR: begin
        next_state = ST_EXEC;
        alu_op     = ALU_OP_OR;
      end
      OPC_ADD:  next_state = ST_READ_RS;
      OPC_JMP:  next_state = ST_FETCH;
      default:  is_legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctl_fsm.sv
// rtl/ctl_fsm.sv - fetch/decode/execute/writeback sequencer with halt, jump and trap
module ctl_fsm
  import ctl_fsm_pkg::*;
#(
  parameter int                 WORD_LEN = 64,
  parameter int                 PC_LEN   = 32,
  parameter logic [PC_LEN-1:0]  RESET_PC = '0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  output logic                 inst_req_o,
  input  logic                 inst_valid_i,
  input  logic [31:0]          inst_i,
  output logic [PC_LEN-1:0]    pc_o,
  output reg_t                 reg_rd_id_o,
  input  logic [WORD_LEN-1:0]  reg_value_i,
  output logic                 reg_write_en_o,
  output reg_t                 reg_id_o,
  output logic [WORD_LEN-1:0]  reg_value_o,
  output logic [WORD_LEN-1:0]  alu_op_a_o,
  output logic [WORD_LEN-1:0]  alu_op_b_o,
  output alu_op_t              alu_opc_o,
  input  logic [WORD_LEN-1:0]  alu_op_res_i,
  input  logic                 wake_i,
  output logic                 halted_o,
  output logic                 trap_o
);

  ctl_state_t          state_q, state_d;
  logic [31:0]         inst_q;
  logic [PC_LEN-1:0]   pc_q;
  logic [WORD_LEN-1:0] reg_value_q, alu_a_q, alu_b_q;
  alu_op_t             alu_opc_q;
  reg_t                reg_id_q;
  logic                wr_en_q;
  logic                accept;

  ctl_state_t          dec_next;
  alu_op_t             dec_alu_op;
  logic                dec_legal;

  logic [WORD_LEN-1:0] imm_ext;
  logic [PC_LEN-1:0]   jmp_target;

  assign imm_ext    = WORD_LEN'(inst_imm(inst_q));
  assign jmp_target = PC_LEN'({inst_imm(inst_q), 2'b00});

  ctl_decode u_decode (
    .opcode     (inst_opc(inst_q)),
    .next_state (dec_next),
    .alu_op     (dec_alu_op),
    .is_legal   (dec_legal)
  );

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    inst_req_o  = 1'b0;
    halted_o    = 1'b0;
    trap_o      = 1'b0;
    reg_rd_id_o = '0;
    case (state_q)
      ST_FETCH: begin
        inst_req_o = 1'b1;
        if (inst_valid_i) begin
          accept  = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        reg_rd_id_o = inst_rd(inst_q);
        state_d     = dec_legal ? dec_next : ST_TRAP;
      end
      ST_READ_RS: begin
        reg_rd_id_o = inst_rs(inst_q);
        state_d     = ST_EXEC;
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: begin
        halted_o = 1'b1;
        if (wake_i) state_d = ST_FETCH;
      end
      ST_TRAP: trap_o = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  // Write strobe is derived from the next state so it is high exactly while in WB.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      reg_value_q <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_opc_q   <= ALU_OP_ADD;
      reg_id_q    <= '0;
      wr_en_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= (state_d == ST_WB);
      if (accept) begin
        inst_q <= inst_i;
        pc_q   <= pc_q + PC_LEN'(4);
      end
      if (state_q == ST_DECODE) begin
        if (inst_opc(inst_q) == OPC_IMOV) reg_value_q <= imm_ext;
        if (inst_opc(inst_q) == OPC_JMP)  pc_q <= jmp_target;
        if (state_d == ST_EXEC || state_d == ST_READ_RS) begin
          alu_a_q   <= reg_value_i;
          alu_opc_q <= dec_alu_op;
        end
        if (state_d == ST_EXEC) alu_b_q <= imm_ext;
        if (state_d == ST_WB || state_d == ST_EXEC || state_d == ST_READ_RS)
          reg_id_q <= inst_rd(inst_q);
      end
      if (state_q == ST_READ_RS) alu_b_q <= reg_value_i;
      if (state_q == ST_EXEC) reg_value_q <= alu_op_res_i;
    end
  end

  assign pc_o           = pc_q;
  assign reg_write_en_o = wr_en_q;
  assign reg_id_o       = reg_id_q;
  assign reg_value_o    = reg_value_q;
  assign alu_op_a_o     = alu_a_q;
  assign alu_op_b_o     = alu_b_q;
  assign alu_opc_o      = alu_opc_q;

endmodule
